// File: rtl/vp_bbox_overlay_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vp_bbox_overlay_if                                            |
// | Description : Parallel video stream bundle (DE, HSYNC, VSYNC, 24-bit RGB)   |
// |               shared by the bounding-box overlay input and output sides.    |
// |   de     : data enable, high on active pixels                              |
// |   hsync  : horizontal sync, active-high pulse                              |
// |   vsync  : vertical sync, active-high pulse                                |
// |   pixel  : {r[7:0], g[7:0], b[7:0]}                                        |
// |   master : drives the stream, slave : consumes it                          |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface vp_bbox_overlay_if;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [23:0] pixel;

  modport master (output de, hsync, vsync, pixel);
  modport slave  (input  de, hsync, vsync, pixel);
endinterface
`default_nettype wire

// File: rtl/vp_bbox_overlay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vp_bbox_overlay                                               |
// | Description : Measures the bounding box of foreground pixels (red channel   |
// |               above THRESH) in each frame, latches it at the vsync rising   |
// |               edge, and redraws the stream with the previous frame's box    |
// |               overlaid as a 1-pixel BOX_COLOR border.                       |
// | Ports       :                                                               |
// |   clk        in   pixel clock                                               |
// |   rst_n      in   asynchronous active-low reset                             |
// |   overlay_en in   1 = draw the box, 0 = pass pixels through                 |
// |   vid_in     in   de_in / hsync_in / vsync_in / pixel_in stream             |
// |   vid_out    out  de_out / hsync_out / vsync_out / pixel_out, 1 clk later   |
// |   x_min..y_max out latched box edges                                        |
// |   box_valid  out  latched box came from a frame with foreground             |
// |   frame_done out  1-clk pulse when the box registers update                 |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module vp_bbox_overlay #(
  parameter int          CW        = 11,
  parameter logic [7:0]  THRESH    = 8'd127,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          overlay_en,
  vp_bbox_overlay_if.slave   vid_in,
  vp_bbox_overlay_if.master  vid_out,
  output logic      [CW-1:0] x_min,
  output logic      [CW-1:0] x_max,
  output logic      [CW-1:0] y_min,
  output logic      [CW-1:0] y_max,
  output logic               box_valid,
  output logic               frame_done
);

  localparam logic [CW-1:0] c_ones = {CW{1'b1}};
  localparam logic [CW-1:0] c_zero = {CW{1'b0}};
  localparam logic [CW-1:0] c_one  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;

  // 1-clk delayed copies of the input stream; also the edge-detect history
  logic          r_de_d;
  logic          r_hs_d;
  logic          r_vs_d;
  logic [23:0]   r_pixel;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;

  // running statistics of the frame in progress
  logic [CW-1:0] r_xmin_run;
  logic [CW-1:0] r_xmax_run;
  logic [CW-1:0] r_ymin_run;
  logic [CW-1:0] r_ymax_run;
  logic          r_found;

  logic          w_de_fall;
  logic          w_frame_start;
  logic          w_fg;
  logic [CW-1:0] w_xmin_n;
  logic [CW-1:0] w_xmax_n;
  logic [CW-1:0] w_ymin_n;
  logic [CW-1:0] w_ymax_n;
  logic          w_found_n;
  logic          w_in_x;
  logic          w_in_y;
  logic          w_bx;
  logic          w_by;
  logic          w_border;

  assign w_de_fall     = ~vid_in.de & r_de_d;
  assign w_frame_start = vid_in.vsync & ~r_vs_d;
  assign w_fg          = vid_in.de & (vid_in.pixel[23:16] > THRESH);

  // Stats including the current pixel. Latching these (rather than the
  // registered stats) keeps a foreground pixel that coincides with the
  // frame boundary inside the box being latched.
  assign w_xmin_n  = (w_fg && (r_x < r_xmin_run)) ? r_x : r_xmin_run;
  assign w_xmax_n  = (w_fg && (r_x > r_xmax_run)) ? r_x : r_xmax_run;
  assign w_ymin_n  = (w_fg && (r_y < r_ymin_run)) ? r_y : r_ymin_run;
  assign w_ymax_n  = (w_fg && (r_y > r_ymax_run)) ? r_y : r_ymax_run;
  assign w_found_n = r_found | w_fg;

  // Border test against the latched box of the previous frame
  assign w_in_x   = (r_x >= x_min) && (r_x <= x_max);
  assign w_in_y   = (r_y >= y_min) && (r_y <= y_max);
  assign w_bx     = ((r_x == x_min) || (r_x == x_max)) && w_in_y;
  assign w_by     = ((r_y == y_min) || (r_y == y_max)) && w_in_x;
  assign w_border = box_valid & overlay_en & vid_in.de & (w_bx | w_by);

  // Stream delay and overlay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_d  <= 1'b0;
      r_hs_d  <= 1'b0;
      r_vs_d  <= 1'b0;
      r_pixel <= 24'h000000;
    end else begin
      r_de_d  <= vid_in.de;
      r_hs_d  <= vid_in.hsync;
      r_vs_d  <= vid_in.vsync;
      r_pixel <= w_border ? BOX_COLOR : vid_in.pixel;
    end
  end

  assign vid_out.de    = r_de_d;
  assign vid_out.hsync = r_hs_d;
  assign vid_out.vsync = r_vs_d;
  assign vid_out.pixel = r_pixel;

  // Coordinate counters, wrapping modulo 2^CW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= c_zero;
      r_y <= c_zero;
    end else begin
      if (vid_in.de) begin
        r_x <= r_x + c_one;
      end else begin
        r_x <= c_zero;
      end
      if (w_frame_start) begin
        r_y <= c_zero;
      end else if (w_de_fall) begin
        r_y <= r_y + c_one;
      end
    end
  end

  // Frame FSM with running stats and latched box. IDLE swallows the first
  // boundary after reset because the frame in flight at reset was partial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_xmin_run <= c_ones;
      r_xmax_run <= c_zero;
      r_ymin_run <= c_ones;
      r_ymax_run <= c_zero;
      r_found    <= 1'b0;
      x_min      <= c_zero;
      x_max      <= c_zero;
      y_min      <= c_zero;
      y_max      <= c_zero;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (w_frame_start) begin
        r_xmin_run <= c_ones;
        r_xmax_run <= c_zero;
        r_ymin_run <= c_ones;
        r_ymax_run <= c_zero;
        r_found    <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            x_min      <= w_xmin_n;
            x_max      <= w_xmax_n;
            y_min      <= w_ymin_n;
            y_max      <= w_ymax_n;
            box_valid  <= w_found_n;
            frame_done <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end else begin
        r_xmin_run <= w_xmin_n;
        r_xmax_run <= w_xmax_n;
        r_ymin_run <= w_ymin_n;
        r_ymax_run <= w_ymax_n;
        r_found    <= w_found_n;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vp_bbox_overlay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vp_bbox_overlay                                            |
// | Description : Self-checking bench for vp_bbox_overlay. Streams 64x64        |
// |               frames built from an image array and predicts every output   |
// |               cycle from a frame-level bounding-box model.                 |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_vp_bbox_overlay;
  localparam int          CW     = 11;
  localparam int          W      = 64;
  localparam int          H      = 64;
  localparam int          HB     = 6;
  localparam int          LW     = W + HB;
  localparam int          NPRE   = 5;
  localparam int          NTOT   = NPRE + H * LW + 2;
  localparam logic [23:0] RED    = 24'hFF0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          overlay_en = 1'b0;
  logic [CW-1:0] x_min, x_max, y_min, y_max;
  logic          box_valid, frame_done;

  vp_bbox_overlay_if vin ();
  vp_bbox_overlay_if vout ();

  vp_bbox_overlay #(.CW(CW), .THRESH(8'd127), .BOX_COLOR(RED)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .overlay_en (overlay_en),
    .vid_in     (vin),
    .vid_out    (vout),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .box_valid  (box_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] img [H][W];

  // model: latched box as seen on the outputs
  bit m_armed;
  bit m_valid;
  int m_xmin, m_xmax, m_ymin, m_ymax;
  // model: bounding box of the last frame streamed (latched at next vsync)
  bit p_found;
  int p_xmin, p_xmax, p_ymin, p_ymax;

  int red_cnt;
  int done_seen;
  int en_mode;
  bit ov;

  function automatic logic [23:0] bg_pix();
    return {1'b0, 7'($urandom), 16'($urandom)};
  endfunction

  function automatic logic [23:0] fg_pix();
    return {1'b1, 7'($urandom), 8'($urandom) | 8'h01, 8'($urandom)};
  endfunction

  function automatic logic [23:0] blank_pix();
    return 24'($urandom) | 24'h000001;
  endfunction

  function automatic bit pick_en();
    if (en_mode == 1) return 1'($urandom_range(0, 1));
    return ov;
  endfunction

  task automatic compute_pending();
    p_found = 1'b0;
    p_xmin = 2047; p_xmax = 0; p_ymin = 2047; p_ymax = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (img[r][c][23:16] > 8'd127) begin
          p_found = 1'b1;
          if (c < p_xmin) p_xmin = c;
          if (c > p_xmax) p_xmax = c;
          if (r < p_ymin) p_ymin = r;
          if (r > p_ymax) p_ymax = r;
        end
  endtask

  task automatic fill_black();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 24'h000000;
  endtask

  task automatic fill_rect(input int x0, input int x1, input int y0, input int y1, input int dens);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c] = bg_pix();
        if (c >= x0 && c <= x1 && r >= y0 && r <= y1 && $urandom_range(0, dens - 1) == 0)
          img[r][c] = fg_pix();
      end
  endtask

  task automatic drive(input bit de, input bit hs, input bit vs, input logic [23:0] pix, input bit en);
    vin.de = de; vin.hsync = hs; vin.vsync = vs; vin.pixel = pix; overlay_en = en;
    @(posedge clk);
    #1;
  endtask

  // Streams img as one frame (vsync, blanking, 64 lines) and checks every
  // output cycle. abort_row >= 0 returns early in the middle of that row.
  task automatic send_frame(input int abort_row);
    bit de, hs, vs, en, border, e_done;
    int row, col, k;
    logic [23:0] pix, e_pix;
    logic [4*CW+1:0] e_box;
    red_cnt = 0;
    done_seen = 0;
    for (int n = 0; n < NTOT; n++) begin
      de = 1'b0; hs = 1'b0; vs = 1'b0; e_done = 1'b0;
      row = -1; col = -1;
      if (n < NPRE) begin
        vs = (n < 2);
        if (n == 0) begin
          if (m_armed) begin
            m_xmin = p_xmin; m_xmax = p_xmax; m_ymin = p_ymin; m_ymax = p_ymax;
            m_valid = p_found; e_done = 1'b1;
          end
          m_armed = 1'b1;
          compute_pending();
        end
      end else if (n < NPRE + H * LW) begin
        k = n - NPRE;
        row = k / LW;
        col = k % LW;
        de = (col < W);
        hs = (col >= W + 1) && (col < W + 4);
        if (row == abort_row && col == 20) return;
      end
      pix = de ? img[row][col] : blank_pix();
      en = pick_en();
      border = de && m_valid && en &&
               ((((col == m_xmin) || (col == m_xmax)) && row >= m_ymin && row <= m_ymax) ||
                (((row == m_ymin) || (row == m_ymax)) && col >= m_xmin && col <= m_xmax));
      e_pix = border ? RED : pix;
      e_box = {CW'(m_xmin), CW'(m_xmax), CW'(m_ymin), CW'(m_ymax), m_valid, e_done};
      drive(de, hs, vs, pix, en);
      checks++;
      if ({vout.de, vout.hsync, vout.vsync, vout.pixel} !== {de, hs, vs, e_pix}) begin
        errors++;
        $display("FAIL video n=%0d row=%0d col=%0d got de/hs/vs/pix=%b%b%b/%h exp %b%b%b/%h",
                 n, row, col, vout.de, vout.hsync, vout.vsync, vout.pixel, de, hs, vs, e_pix);
      end
      checks++;
      if ({x_min, x_max, y_min, y_max, box_valid, frame_done} !== e_box) begin
        errors++;
        $display("FAIL box n=%0d got x=%0d..%0d y=%0d..%0d v=%b fd=%b exp x=%0d..%0d y=%0d..%0d v=%b fd=%b",
                 n, x_min, x_max, y_min, y_max, box_valid, frame_done,
                 m_xmin, m_xmax, m_ymin, m_ymax, m_valid, e_done);
      end
      if (de && vout.pixel === RED) red_cnt++;
      if (frame_done === 1'b1) done_seen++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vin.de = 1'b1; vin.hsync = 1'b1; vin.vsync = 1'b1; vin.pixel = fg_pix(); overlay_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vout.de, vout.hsync, vout.vsync, vout.pixel} !== 27'd0) begin
      errors++;
      $display("FAIL reset_video got %b%b%b/%h exp 000/000000", vout.de, vout.hsync, vout.vsync, vout.pixel);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, box_valid, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_box got %0d %0d %0d %0d %b %b exp all 0", x_min, x_max, y_min, y_max, box_valid, frame_done);
    end
    m_armed = 1'b0; m_valid = 1'b0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    vin.de = 1'b0; vin.hsync = 1'b0; vin.vsync = 1'b0; vin.pixel = 24'h0; overlay_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arming();
    ov = 1'b1; en_mode = 0;
    fill_black();
    img[20][10] = fg_pix();
    send_frame(-1);
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL arm_no_done got %0d pulses exp 0", done_seen);
    end
    fill_black();
    send_frame(-1);
    checks++;
    if (done_seen != 1) begin
      errors++; $display("FAIL arm_done got %0d pulses exp 1", done_seen);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, box_valid} !== {11'd10, 11'd10, 11'd20, 11'd20, 1'b1}) begin
      errors++;
      $display("FAIL arm_box got %0d/%0d/%0d/%0d v=%b exp 10/10/20/20 v=1", x_min, x_max, y_min, y_max, box_valid);
    end
  endtask

  task automatic test_black();
    ov = 1'b1; en_mode = 0;
    fill_rect(5, 40, 8, 50, 1);
    send_frame(-1);
    checks++;
    if ({x_min, x_max, y_min, y_max, box_valid} !== {11'd2047, 11'd0, 11'd2047, 11'd0, 1'b0}) begin
      errors++;
      $display("FAIL black_box got %0d/%0d/%0d/%0d v=%b exp 2047/0/2047/0 v=0", x_min, x_max, y_min, y_max, box_valid);
    end
    checks++;
    if (red_cnt != 0) begin
      errors++; $display("FAIL black_red got %0d exp 0", red_cnt);
    end
  endtask

  task automatic test_rect();
    ov = 1'b1; en_mode = 0;
    fill_rect(5, 40, 8, 50, 1);
    send_frame(-1);
    checks++;
    if ({x_min, x_max, y_min, y_max, box_valid} !== {11'd5, 11'd40, 11'd8, 11'd50, 1'b1}) begin
      errors++;
      $display("FAIL rect_box got %0d/%0d/%0d/%0d v=%b exp 5/40/8/50 v=1", x_min, x_max, y_min, y_max, box_valid);
    end
    checks++;
    if (red_cnt != 154) begin
      errors++; $display("FAIL rect_border got %0d exp 154", red_cnt);
    end
  endtask

  task automatic test_overlay_off();
    ov = 1'b0; en_mode = 0;
    fill_rect(5, 40, 8, 50, 1);
    send_frame(-1);
    checks++;
    if (red_cnt != 0) begin
      errors++; $display("FAIL off_red got %0d exp 0", red_cnt);
    end
    checks++;
    if (done_seen != 1) begin
      errors++; $display("FAIL off_done got %0d exp 1", done_seen);
    end
  endtask

  task automatic test_thresh();
    ov = 1'b1; en_mode = 0;
    fill_black();
    img[3][3]   = {8'd128, 8'h10, 8'h20};
    img[50][50] = {8'd127, 8'h10, 8'h20};
    send_frame(-1);
    fill_rect(0, 63, 0, 63, 16);
    send_frame(-1);
    checks++;
    if ({x_min, x_max, y_min, y_max, box_valid} !== {11'd3, 11'd3, 11'd3, 11'd3, 1'b1}) begin
      errors++;
      $display("FAIL thresh_box got %0d/%0d/%0d/%0d v=%b exp 3/3/3/3 v=1", x_min, x_max, y_min, y_max, box_valid);
    end
  endtask

  task automatic test_random();
    int x0, x1, y0, y1;
    for (int f = 0; f < 3; f++) begin
      x0 = $urandom_range(0, 63); x1 = $urandom_range(x0, 63);
      y0 = $urandom_range(0, 63); y1 = $urandom_range(y0, 63);
      ov = 1'b1;
      en_mode = (f == 1) ? 1 : 0;
      fill_rect(x0, x1, y0, y1, 4);
      send_frame(-1);
      checks++;
      if (done_seen != 1) begin
        errors++; $display("FAIL rand_done frame=%0d got %0d exp 1", f, done_seen);
      end
    end
    en_mode = 0;
  endtask

  // One-clk DE+VSYNC pulse carrying a foreground pixel at the boundary.
  // Counters sit at x=0, y=64 (after the last line's DE fall).
  task automatic test_pulse();
    logic [23:0] pix;
    fill_black();
    img[20][10] = fg_pix();
    ov = 1'b0;
    send_frame(-1);
    m_xmin = (p_found && p_xmin < 0) ? p_xmin : 0;
    m_xmax = (p_found && p_xmax > 0) ? p_xmax : 0;
    m_ymin = (p_found && p_ymin < 64) ? p_ymin : 64;
    m_ymax = (p_found && p_ymax > 64) ? p_ymax : 64;
    m_valid = 1'b1;
    p_found = 1'b0; p_xmin = 2047; p_xmax = 0; p_ymin = 2047; p_ymax = 0;
    pix = fg_pix();
    drive(1'b1, 1'b0, 1'b1, pix, 1'b0);
    checks++;
    if ({vout.de, vout.vsync, vout.pixel} !== {1'b1, 1'b1, pix}) begin
      errors++;
      $display("FAIL pulse_video got %b%b/%h exp 11/%h", vout.de, vout.vsync, vout.pixel, pix);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, box_valid, frame_done} !==
        {11'd0, 11'd10, 11'd20, 11'd64, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pulse_box got %0d/%0d/%0d/%0d v=%b fd=%b exp 0/10/20/64 v=1 fd=1",
               x_min, x_max, y_min, y_max, box_valid, frame_done);
    end
    drive(1'b0, 1'b0, 1'b0, 24'h000001, 1'b0);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL pulse_width got %b exp 0", frame_done);
    end
    fill_black();
    send_frame(-1);
    checks++;
    if (box_valid !== 1'b0) begin
      errors++; $display("FAIL pulse_empty_valid got %b exp 0", box_valid);
    end
  endtask

  task automatic test_reset_midframe();
    ov = 1'b1; en_mode = 0;
    fill_rect(5, 40, 8, 50, 1);
    send_frame(30);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vout.de, vout.hsync, vout.vsync, vout.pixel, x_min, x_max, y_min, y_max, box_valid, frame_done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got de=%b pix=%h box=%0d/%0d/%0d/%0d v=%b exp all 0",
               vout.de, vout.pixel, x_min, x_max, y_min, y_max, box_valid);
    end
    m_armed = 1'b0; m_valid = 1'b0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    #4;
    rst_n = 1'b1;
    fill_rect(5, 40, 8, 50, 1);
    send_frame(-1);
    checks++;
    if (done_seen != 0 || box_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_arm got done=%0d v=%b exp done=0 v=0", done_seen, box_valid);
    end
    fill_black();
    send_frame(-1);
    checks++;
    if ({x_min, x_max, y_min, y_max, box_valid} !== {11'd5, 11'd40, 11'd8, 11'd50, 1'b1} || done_seen != 1) begin
      errors++;
      $display("FAIL midreset_latch got %0d/%0d/%0d/%0d v=%b done=%0d exp 5/40/8/50 v=1 done=1",
               x_min, x_max, y_min, y_max, box_valid, done_seen);
    end
  endtask

  initial begin
    en_mode = 0;
    ov = 1'b0;
    test_reset();
    test_arming();
    test_black();
    test_rect();
    test_overlay_off();
    test_thresh();
    test_random();
    test_pulse();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vp_bbox_overlay.md
Name: vp_bbox_overlay

Overview:
- Downstream consumer of the 64x64 video source / HDMI-in stage in the vis_bounding_box pipeline.
- Takes a binary-thresholded RGB pixel stream with DE/HSYNC/VSYNC and tracks the coordinates of every foreground pixel in the frame.
- At each frame boundary it latches the bounding box of the foreground.
- It redraws the stream with that box overlaid as a 1-pixel border; the box drawn in frame N is the box measured in frame N-1. Box coordinates are also exported for software and debug.

Parameters:
- CW, 11, width of the x/y coordinate counters and box outputs.
- THRESH, 8'd127, a pixel is foreground when its red channel is strictly greater than THRESH.
- BOX_COLOR, 24'hFF0000, RGB value written on box border pixels, ordered {r,g,b}.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- overlay_en  in  1  1 = draw the box; 0 = pass pixels through.
- de_in  in  1  data enable.
- hsync_in  in  1  horizontal sync, active-high pulse.
- vsync_in  in  1  vertical sync, active-high pulse.
- pixel_in  in  24  {r[7:0],g[7:0],b[7:0]}.
- de_out  out  1  de_in delayed 1 clk.
- hsync_out  out  1  hsync_in delayed 1 clk.
- vsync_out  out  1  vsync_in delayed 1 clk.
- pixel_out  out  24  overlaid pixel, aligned with de_out.
- x_min  out  CW  latched box left edge.
- x_max  out  CW  latched box right edge.
- y_min  out  CW  latched box top edge.
- y_max  out  CW  latched box bottom edge.
- box_valid  out  1  the latched box came from a frame that contained at least one foreground pixel.
- frame_done  out  1  one-clk pulse each time the box registers are updated.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - all outputs 0; x_min/y_min outputs also 0.
  - internal running x_min/y_min set to all-ones; running x_max/y_max set to 0.
  - found=0, armed=0; x and y counters 0.
- Coordinate counters:
  - x increments on each clk with de_in=1 and clears to 0 when de_in=0.
  - y increments on each falling edge of de_in (de_in=0 and the registered de_in=1).
  - y clears on the rising edge of vsync_in.
  - Both counters are CW-bit and wrap modulo 2^CW; no saturation.
- Foreground test: fg = de_in & (pixel_in[23:16] > THRESH), an unsigned compare.
- Running stats, on each fg cycle:
  - x_min_r = min(x_min_r, x); x_max_r = max(x_max_r, x).
  - y_min_r = min(y_min_r, y); y_max_r = max(y_max_r, y).
  - found = 1.
- Frame boundary = rising edge of vsync_in (vsync_in=1 and the registered vsync_in=0).
- Two-state FSM:
  - IDLE (after reset): on a frame boundary, clear the running stats and go to RUN. No latch and no frame_done, because the frame in progress at reset release was partial.
  - RUN: on a frame boundary, copy the running stats to the outputs, set box_valid = found, pulse frame_done for exactly 1 clk, then clear the running stats and found. Stay in RUN.
- Simultaneous fg and frame boundary in the same clk: the fg pixel is included in the latched values. The running stats then restart empty.
- If found=0 at a latch, the box outputs take the running reset values (min all-ones, max 0) and box_valid=0.
- Overlay, registered with 1-clk latency:
  - border = box_valid & overlay_en & de_in & (bx | by).
  - bx = (x==x_min | x==x_max) & y_min<=y<=y_max.
  - by = (y==y_min | y==y_max) & x_min<=x<=x_max.
  - pixel_out = border ? BOX_COLOR : pixel_in.
  - When de_in=0, pixel_out = pixel_in delayed (no forcing to 0).
- Sync, DE and pixel delays are all exactly 1 clk, so relative timing is preserved.
- A box update at the frame boundary takes effect from the first active pixel of the new frame. There is no tearing, because updates occur only outside the active region.
- Reset mid-frame: all state clears immediately, outputs go to 0 and the FSM returns to IDLE. The first full frame after that is measured and latched at the second vsync rise.
- overlay_en is sampled every clk. Toggling it mid-line affects only the pixels of the clk in which it changes.

Test Plan:
- Reset then one 64x64 frame with fg only at (10,20) -> at the first vsync rise: no frame_done (IDLE→RUN). A second identical frame -> at the next vsync rise: frame_done=1 for 1 clk, x_min=x_max=10, y_min=y_max=20, box_valid=1.
- All-black frame after a valid one -> at the boundary: box_valid=0, x_min=y_min=2047, x_max=y_max=0. The next frame's pixel_out equals pixel_in delayed, with no red pixels.
- fg rectangle x 5..40, y 8..50, overlay_en=1 -> latch gives 5/40/8/50. In the next frame, pixel_out=FF0000 exactly on the border (row 8 x5..40, column 40 y8..50, etc.) and passthrough elsewhere. Count 154 border pixels.
- Same stream with overlay_en=0 -> pixel_out equals pixel_in delayed everywhere. Box outputs are still updated.
- pixel r=127 vs r=128 at (3,3) -> only r=128 counts as foreground (box 3/3/3/3).
- Assert rst_n=0 at line 30 of a frame -> all outputs 0 immediately, then the IDLE/arming sequence. A one-cycle DE/VS pulse coincident with fg at a vsync rise is included in the latch.
